// File: rtl/cursor_ctrl.sv
// cursor_ctrl: PS/2-driven cursor position controller for the VGA overlay.
//   Decodes make/break/E0-extended scancodes into a held-key mask (up, down,
//   left, right) plus a home request, and steps posx/posy at a fixed rate
//   while direction keys are held. Edge policy is selected by BOUND_MODE.
// Optional feature: define ACCEL_EN to enable staged step acceleration
//   (STEP, 2*STEP, 4*STEP every ACCEL_TICKS ticks).
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   flag     in   one-cycle strobe, scancode valid
//   scancode in   byte from PS/2 receiver
//   posx     out  cursor x (X_W bits)
//   posy     out  cursor y (Y_W bits)
//   moving   out  any axis has a non-cancelled direction held
module cursor_ctrl #(
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned X_MIN       = 48,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MIN       = 35,
  parameter int unsigned Y_MAX       = 418,
  parameter int unsigned X_HOME      = 364,
  parameter int unsigned Y_HOME      = 227,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RATE_DIV    = 4,
  parameter int unsigned BOUND_MODE  = 0,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flag,
  input  logic [7:0]     scancode,
  output logic [X_W-1:0] posx,
  output logic [Y_W-1:0] posy,
  output logic           moving
);

  // Candidates carry a sign bit plus one headroom bit so no move can alias.
  localparam int unsigned XC_W = X_W + 2;
  localparam int unsigned YC_W = Y_W + 2;
  localparam int unsigned SW   = 16;
  localparam int unsigned RC_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DN   = 8'h72;
  localparam logic [7:0] SC_LF   = 8'h6B;
  localparam logic [7:0] SC_RT   = 8'h74;
  localparam logic [7:0] SC_HOME = 8'h6C;

  localparam int unsigned H_UP = 0;
  localparam int unsigned H_DN = 1;
  localparam int unsigned H_LF = 2;
  localparam int unsigned H_RT = 3;

  // Elaboration-time parameter sanity checks.
  if (RATE_DIV < 1) begin : g_bad_rate
    $error("cursor_ctrl: RATE_DIV must be >= 1");
  end
  if (ACCEL_TICKS < 1) begin : g_bad_accel
    $error("cursor_ctrl: ACCEL_TICKS must be >= 1");
  end
  if (BOUND_MODE > 2) begin : g_bad_bound
    $error("cursor_ctrl: BOUND_MODE must be 0, 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_make;
  logic             w_brk;
  logic [3:0]       r_held;
  logic [3:0]       w_held_nxt;
  logic             w_home_req;
  logic             w_right;
  logic             w_left;
  logic             w_down;
  logic             w_up;
  logic             w_moving;
  logic [RC_W-1:0]  r_rate;
  logic             w_tick;
  logic [SW-1:0]    w_step;
  logic [X_W-1:0]   r_posx;
  logic [Y_W-1:0]   r_posy;
  logic [X_W-1:0]   w_posx_nxt;
  logic [Y_W-1:0]   w_posy_nxt;
  logic [XC_W-1:0]  w_x_cand;
  logic [YC_W-1:0]  w_y_cand;
  logic             w_x_over;
  logic             w_x_under;
  logic             w_y_over;
  logic             w_y_under;

  // Decoder state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Decoder next state; only a strobed byte advances it.
  always_comb begin
    w_state_nxt = r_state;
    if (flag) begin
      unique case (r_state)
        S_IDLE: begin
          if (scancode == SC_EXT)      w_state_nxt = S_EXT;
          else if (scancode == SC_BRK) w_state_nxt = S_BRK;
          else                         w_state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (scancode == SC_BRK) w_state_nxt = S_EXT_BRK;
          else                    w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Decoder outputs: make/break strobes for the current byte.
  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    if (flag) begin
      unique case (r_state)
        S_IDLE:  w_make = (scancode != SC_EXT) && (scancode != SC_BRK);
        S_EXT:   w_make = (scancode != SC_BRK);
        default: w_brk  = 1'b1;
      endcase
    end
  end

  assign w_home_req = w_make && (scancode == SC_HOME);

  // Held-mask update; unknown codes leave the mask alone.
  always_comb begin
    w_held_nxt = r_held;
    unique case (scancode)
      SC_UP:   w_held_nxt[H_UP] = w_make;
      SC_DN:   w_held_nxt[H_DN] = w_make;
      SC_LF:   w_held_nxt[H_LF] = w_make;
      SC_RT:   w_held_nxt[H_RT] = w_make;
      default: w_held_nxt = r_held;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_held <= '0;
    else if (w_make || w_brk) r_held <= w_held_nxt;
  end

  // Opposite keys cancel per axis.
  assign w_right  = r_held[H_RT] & ~r_held[H_LF];
  assign w_left   = r_held[H_LF] & ~r_held[H_RT];
  assign w_down   = r_held[H_DN] & ~r_held[H_UP];
  assign w_up     = r_held[H_UP] & ~r_held[H_DN];
  assign w_moving = w_right | w_left | w_down | w_up;
  assign moving   = w_moving;

  // Rate divider: ticks on the first moving cycle, then every RATE_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_rate <= '0;
    else if (w_home_req || !w_moving)   r_rate <= '0;
    else if (r_rate == RC_W'(RATE_DIV - 1)) r_rate <= '0;
    else                                r_rate <= r_rate + RC_W'(1);
  end

  assign w_tick = w_moving && (r_rate == '0);

`ifdef ACCEL_EN
  localparam int unsigned AC_MAX = 2 * ACCEL_TICKS;
  localparam int unsigned AC_W   = $clog2(AC_MAX + 1);

  logic [AC_W-1:0] r_acc;

  // Ticks taken in the current hold, saturating at the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_acc <= '0;
    else if (w_home_req || !w_moving) r_acc <= '0;
    else if (w_tick && (r_acc != AC_W'(AC_MAX))) r_acc <= r_acc + AC_W'(1);
  end

  always_comb begin
    if (r_acc < AC_W'(ACCEL_TICKS))   w_step = SW'(STEP);
    else if (r_acc < AC_W'(AC_MAX))   w_step = SW'(2 * STEP);
    else                              w_step = SW'(4 * STEP);
  end
`else
  assign w_step = SW'(STEP);
`endif

  // X axis: candidate move and boundary policy.
  always_comb begin
    w_x_cand = XC_W'(r_posx);
    if (w_right)     w_x_cand = XC_W'(r_posx) + XC_W'(w_step);
    else if (w_left) w_x_cand = XC_W'(r_posx) - XC_W'(w_step);
    w_x_under = w_x_cand[XC_W-1] || (w_x_cand < XC_W'(X_MIN));
    w_x_over  = !w_x_cand[XC_W-1] && (w_x_cand > XC_W'(X_MAX));
    w_posx_nxt = r_posx;
    if (w_tick && (w_right || w_left)) begin
      if (w_x_over) begin
        if (BOUND_MODE == 1)      w_posx_nxt = X_W'(X_MAX);
        else if (BOUND_MODE == 2) w_posx_nxt = X_W'(X_MIN);
        else                      w_posx_nxt = X_W'(X_HOME);
      end else if (w_x_under) begin
        if (BOUND_MODE == 1)      w_posx_nxt = X_W'(X_MIN);
        else if (BOUND_MODE == 2) w_posx_nxt = X_W'(X_MAX);
        else                      w_posx_nxt = X_W'(X_HOME);
      end else begin
        w_posx_nxt = X_W'(w_x_cand);
      end
    end
  end

  // Y axis: candidate move and boundary policy.
  always_comb begin
    w_y_cand = YC_W'(r_posy);
    if (w_down)    w_y_cand = YC_W'(r_posy) + YC_W'(w_step);
    else if (w_up) w_y_cand = YC_W'(r_posy) - YC_W'(w_step);
    w_y_under = w_y_cand[YC_W-1] || (w_y_cand < YC_W'(Y_MIN));
    w_y_over  = !w_y_cand[YC_W-1] && (w_y_cand > YC_W'(Y_MAX));
    w_posy_nxt = r_posy;
    if (w_tick && (w_down || w_up)) begin
      if (w_y_over) begin
        if (BOUND_MODE == 1)      w_posy_nxt = Y_W'(Y_MAX);
        else if (BOUND_MODE == 2) w_posy_nxt = Y_W'(Y_MIN);
        else                      w_posy_nxt = Y_W'(Y_HOME);
      end else if (w_y_under) begin
        if (BOUND_MODE == 1)      w_posy_nxt = Y_W'(Y_MIN);
        else if (BOUND_MODE == 2) w_posy_nxt = Y_W'(Y_MAX);
        else                      w_posy_nxt = Y_W'(Y_HOME);
      end else begin
        w_posy_nxt = Y_W'(w_y_cand);
      end
    end
  end

  // Position registers; a home request outranks a same-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_posx <= X_W'(X_HOME);
      r_posy <= Y_W'(Y_HOME);
    end else if (w_home_req) begin
      r_posx <= X_W'(X_HOME);
      r_posy <= Y_W'(Y_HOME);
    end else begin
      r_posx <= w_posx_nxt;
      r_posy <= w_posy_nxt;
    end
  end

  assign posx = r_posx;
  assign posy = r_posy;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Testbench for cursor_ctrl: three instances (one per boundary policy) share
// stimulus; a cycle-level reference model plus directed vector tables.
module tb_cursor_ctrl;

  localparam int RATE_DIV = 4;
  localparam int STEP     = 1;
  localparam int ACC_T    = 2;
  localparam int XMIN = 48, XMAX = 639, YMIN = 35, YMAX = 418;
  localparam int XH = 364, YH = 227;

  logic       clk;
  logic       reset;
  logic       flag;
  logic [7:0] scancode;
  logic [9:0] posx_o [3];
  logic [8:0] posy_o [3];
  logic       mov_o  [3];

  int n_checks = 0;
  int n_err    = 0;

  cursor_ctrl #(.BOUND_MODE(0), .RATE_DIV(RATE_DIV), .STEP(STEP), .ACCEL_TICKS(ACC_T)) u_m0 (
    .clk(clk), .reset(reset), .flag(flag), .scancode(scancode),
    .posx(posx_o[0]), .posy(posy_o[0]), .moving(mov_o[0]));
  cursor_ctrl #(.BOUND_MODE(1), .RATE_DIV(RATE_DIV), .STEP(STEP), .ACCEL_TICKS(ACC_T)) u_m1 (
    .clk(clk), .reset(reset), .flag(flag), .scancode(scancode),
    .posx(posx_o[1]), .posy(posy_o[1]), .moving(mov_o[1]));
  cursor_ctrl #(.BOUND_MODE(2), .RATE_DIV(RATE_DIV), .STEP(STEP), .ACCEL_TICKS(ACC_T)) u_m2 (
    .clk(clk), .reset(reset), .flag(flag), .scancode(scancode),
    .posx(posx_o[2]), .posy(posy_o[2]), .moving(mov_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mx[3], my[3], mcnt[3], macc[3];
  bit h_up, h_dn, h_lf, h_rt, p_ext, p_brk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = XH; my[i] = YH; mcnt[i] = 0; macc[i] = 0;
    end
    h_up = 0; h_dn = 0; h_lf = 0; h_rt = 0; p_ext = 0; p_brk = 0;
  endtask

  function automatic int apply_bound(int c, int lo, int hi, int home, int mode);
    if (c > hi) return (mode == 0) ? home : (mode == 1) ? hi : lo;
    if (c < lo) return (mode == 0) ? home : (mode == 1) ? lo : hi;
    return c;
  endfunction

  function automatic int step_of(int ticks);
`ifdef ACCEL_EN
    if (ticks < ACC_T) return STEP;
    if (ticks < 2 * ACC_T) return 2 * STEP;
    return 4 * STEP;
`else
    return STEP + 0 * ticks;
`endif
  endfunction

  task automatic set_key(input logic [7:0] c, input bit v);
    case (c)
      8'h75: h_up = v;
      8'h72: h_dn = v;
      8'h6B: h_lf = v;
      8'h74: h_rt = v;
      default: ;
    endcase
  endtask

  // One clock edge of the model with the inputs that edge samples.
  task automatic model_step(input bit f, input logic [7:0] c);
    int dx, dy, s;
    bit mov, home;
    dx = int'(h_rt) - int'(h_lf);
    dy = int'(h_dn) - int'(h_up);
    mov = (dx != 0) || (dy != 0);
    home = 0;
    if (f) begin
      if (p_brk) begin
        set_key(c, 0); p_brk = 0; p_ext = 0;
      end else if (c == 8'hF0) begin
        p_brk = 1;
      end else if (c == 8'hE0 && !p_ext) begin
        p_ext = 1;
      end else begin
        if (c == 8'h6C) home = 1;
        set_key(c, 1); p_ext = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (home) begin
        mx[i] = XH; my[i] = YH; mcnt[i] = 0; macc[i] = 0;
      end else if (mov) begin
        if (mcnt[i] % RATE_DIV == 0) begin
          s = step_of(macc[i]);
          if (dx != 0) mx[i] = apply_bound(mx[i] + dx * s, XMIN, XMAX, XH, i);
          if (dy != 0) my[i] = apply_bound(my[i] + dy * s, YMIN, YMAX, YH, i);
          if (macc[i] < 2 * ACC_T) macc[i]++;
        end
        mcnt[i]++;
      end else begin
        mcnt[i] = 0; macc[i] = 0;
      end
    end
  endtask

  function automatic bit model_moving();
    return (h_rt != h_lf) || (h_dn != h_up);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s posx[m%0d]", tag, i), int'(posx_o[i]), mx[i]);
      chk($sformatf("%s posy[m%0d]", tag, i), int'(posy_o[i]), my[i]);
      chk($sformatf("%s moving[m%0d]", tag, i), int'(mov_o[i]), int'(model_moving()));
    end
  endtask

  // Drive one cycle, advance the model, compare #1 after the edge.
  task automatic cyc(input bit f, input logic [7:0] c);
    flag = f;
    scancode = c;
    @(posedge clk);
    model_step(f, c);
    #1;
    chk_model("cyc");
    flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         f;
    logic [7:0] code;
    int         ex;
    int         ey;
    bit         em;
  } vec_t;

  vec_t tbl[27];
  logic [7:0] pick[14];

  initial begin
    reset = 1'b1;
    flag = 1'b0;
    scancode = 8'h00;
    model_reset();
    do_reset();

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      chk("reset posx", int'(posx_o[i]), XH);
      chk("reset posy", int'(posy_o[i]), YH);
      chk("reset moving", int'(mov_o[i]), 0);
    end

`ifndef ACCEL_EN
    // Down hold/release, diagonal, cancel, home priority (values after each edge).
    tbl[0]  = '{1, 8'hE0, 364, 227, 0};
    tbl[1]  = '{1, 8'h72, 364, 227, 1};
    tbl[2]  = '{0, 8'h00, 364, 228, 1};
    tbl[3]  = '{0, 8'h00, 364, 228, 1};
    tbl[4]  = '{0, 8'h00, 364, 228, 1};
    tbl[5]  = '{0, 8'h00, 364, 228, 1};
    tbl[6]  = '{0, 8'h00, 364, 229, 1};
    tbl[7]  = '{1, 8'hE0, 364, 229, 1};
    tbl[8]  = '{1, 8'hF0, 364, 229, 1};
    tbl[9]  = '{1, 8'h72, 364, 229, 0};
    tbl[10] = '{0, 8'h00, 364, 229, 0};
    tbl[11] = '{1, 8'h74, 364, 229, 1};
    tbl[12] = '{1, 8'h72, 365, 229, 1};
    tbl[13] = '{0, 8'h00, 365, 229, 1};
    tbl[14] = '{0, 8'h00, 365, 229, 1};
    tbl[15] = '{0, 8'h00, 365, 229, 1};
    tbl[16] = '{0, 8'h00, 366, 230, 1};
    tbl[17] = '{1, 8'h6B, 366, 230, 1};
    tbl[18] = '{0, 8'h00, 366, 230, 1};
    tbl[19] = '{0, 8'h00, 366, 230, 1};
    tbl[20] = '{0, 8'h00, 366, 231, 1};
    tbl[21] = '{0, 8'h00, 366, 231, 1};
    tbl[22] = '{0, 8'h00, 366, 231, 1};
    tbl[23] = '{0, 8'h00, 366, 231, 1};
    tbl[24] = '{1, 8'h6C, 364, 227, 1};
    tbl[25] = '{0, 8'h00, 364, 228, 1};
    tbl[26] = '{0, 8'h00, 364, 228, 1};
    for (int v = 0; v < 27; v++) begin
      cyc(tbl[v].f, tbl[v].code);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d posx[m%0d]", v, i), int'(posx_o[i]), tbl[v].ex);
        chk($sformatf("vec%0d posy[m%0d]", v, i), int'(posy_o[i]), tbl[v].ey);
        chk($sformatf("vec%0d moving[m%0d]", v, i), int'(mov_o[i]), int'(tbl[v].em));
      end
    end
`endif

    // Reset in the middle of a hold and a partial E0 F0 sequence.
    cyc(1, 8'h72);
    idle(3);
    cyc(1, 8'hE0);
    cyc(1, 8'hF0);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async reset posx", int'(posx_o[i]), XH);
      chk("async reset posy", int'(posy_o[i]), YH);
      chk("async reset moving", int'(mov_o[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc(1, 8'h72);
    chk("post-reset decode from IDLE", int'(mov_o[0]), 1);
    idle(1);
    chk("post-reset first move", int'(posy_o[0]), YH + 1);
    cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h72);

`ifndef ACCEL_EN
    // X boundary with right held.
    cyc(1, 8'h74);
    for (int n = 0; n < 2000 && mx[0] != XMAX; n++) cyc(0, 8'h00);
    chk("x reaches max in budget", mx[0], XMAX);
    idle(RATE_DIV);
    chk("x bound mode0", int'(posx_o[0]), XH);
    chk("x bound mode1", int'(posx_o[1]), XMAX);
    chk("x bound mode2", int'(posx_o[2]), XMIN);
    cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h74);

    // Y boundary with up held.
    cyc(1, 8'h75);
    for (int n = 0; n < 2000 && my[0] != YMIN; n++) cyc(0, 8'h00);
    chk("y reaches min in budget", my[0], YMIN);
    idle(RATE_DIV);
    chk("y bound mode0", int'(posy_o[0]), YH);
    chk("y bound mode1", int'(posy_o[1]), YMIN);
    chk("y bound mode2", int'(posy_o[2]), YMAX);
    cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h75);
`endif

`ifdef ACCEL_EN
    // Acceleration stages with ACCEL_TICKS=2.
    do_reset();
    begin
      int exp_x[6];
      exp_x[0] = 365; exp_x[1] = 366; exp_x[2] = 368;
      exp_x[3] = 370; exp_x[4] = 374; exp_x[5] = 378;
      cyc(1, 8'h74);
      for (int k = 0; k < 6; k++) begin
        idle(1);
        chk($sformatf("accel tick%0d", k), int'(posx_o[0]), exp_x[k]);
        if (k < 5) idle(RATE_DIV - 1);
      end
      cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h74);
      cyc(1, 8'h74);
      idle(1);
      chk("accel restart step", int'(posx_o[0]), 379);
      cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h74);
    end
`endif

    // Randomized traffic against the model.
    pick[0] = 8'hE0; pick[1] = 8'hE0; pick[2] = 8'hF0; pick[3] = 8'hF0;
    pick[4] = 8'h75; pick[5] = 8'h72; pick[6] = 8'h6B; pick[7] = 8'h74;
    pick[8] = 8'h75; pick[9] = 8'h72; pick[10] = 8'h6B; pick[11] = 8'h74;
    pick[12] = 8'h6C; pick[13] = 8'h1C;
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] c;
      c = pick[$urandom_range(0, 13)];
      if ($urandom_range(0, 19) == 0) c = 8'($urandom);
      cyc($urandom_range(0, 3) == 0, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
